// File: rtl/eth_pkg.sv
// Shared types and constants for the RMII receive path.
package eth_pkg;

  typedef enum logic [2:0] {
    IDLE,
    PREAMBLE,
    DATA,
    EOP,
    DROP
  } rx_state_t;

  localparam logic [31:0] ETH_CRC_POLY    = 32'h04C1_1DB7;
  localparam logic [31:0] ETH_CRC_INIT    = 32'hFFFF_FFFF;
  localparam logic [31:0] ETH_CRC_RESIDUE = 32'hDEBB_20E3;

  localparam logic [1:0] DIBIT_SFD = 2'b11;
  localparam logic [1:0] DIBIT_PRE = 2'b01;

  // Bit-reverse a 32-bit word; the CRC engine shifts LSB-first.
  function automatic logic [31:0] bit_rev32(input logic [31:0] v);
    logic [31:0] r;
    for (int i = 0; i < 32; i++) begin
      r[i] = v[31-i];
    end
    return r;
  endfunction

endpackage

// File: rtl/eth_crc32_byte.sv
// Combinational one-byte step of the reflected Ethernet CRC-32.
module eth_crc32_byte
  import eth_pkg::*;
(
  input  logic [31:0] crc_i,
  input  logic [7:0]  data_i,
  output logic [31:0] crc_o
);

  localparam logic [31:0] PolyRefl = bit_rev32(ETH_CRC_POLY);

  // Eight LSB-first shift steps, data bit 0 first.
  always_comb begin
    crc_o = crc_i;
    for (int i = 0; i < 8; i++) begin
      if (crc_o[0] ^ data_i[i]) begin
        crc_o = (crc_o >> 1) ^ PolyRefl;
      end else begin
        crc_o = crc_o >> 1;
      end
    end
  end

endmodule

// File: rtl/eth_rmii_rx.sv
// RMII 100 Mb/s receive front end: preamble/SFD strip, dibit-to-byte assembly.
// Optional FCS check enabled by defining ETH_RX_CRC_CHECK_EN (adds crc_ok port).
module eth_rmii_rx
  import eth_pkg::*;
#(
  parameter int unsigned MAX_BYTES = 1536
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [1:0] rmii_rx,
  input  logic       crs_dv,
  output logic [7:0] data,
  output logic       valid,
  output logic       eop
`ifdef ETH_RX_CRC_CHECK_EN
  ,
  output logic       crc_ok
`endif
);

  localparam int unsigned CntW = $clog2(MAX_BYTES + 1);

  rx_state_t       state_q, state_d;
  logic [1:0]      rx_q;
  logic            dv_q, dv_prev_q;
  logic [1:0]      idx_q, idx_d;
  logic [5:0]      asm_q, asm_d;
  logic [CntW-1:0] cnt_q, cnt_d;
  logic [7:0]      data_q, data_d;
  logic            valid_q, valid_d;

  logic       sfd;
  logic       frame_end;
  logic       take;
  logic       byte_done;
  logic [7:0] byte_full;

  // Input register for the PHY pins plus one-clock history of dv for end detection.
  always_ff @(posedge clk) begin
    if (reset) begin
      rx_q      <= 2'b00;
      dv_q      <= 1'b0;
      dv_prev_q <= 1'b0;
    end else begin
      rx_q      <= rmii_rx;
      dv_q      <= crs_dv;
      dv_prev_q <= dv_q;
    end
  end

  // State register.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    unique case (state_q)
      IDLE:     if (dv_q) state_d = PREAMBLE;
      PREAMBLE: begin
        if (!dv_q) begin
          state_d = IDLE;
        end else if (rx_q == DIBIT_SFD) begin
          state_d = DATA;
        end else if (rx_q == 2'b10) begin
          state_d = DROP;
        end
      end
      DATA:     if (frame_end) state_d = EOP;
      EOP:      state_d = IDLE;
      DROP:     if (frame_end) state_d = IDLE;
      default:  state_d = IDLE;
    endcase
  end

  // FSM outputs.
  always_comb begin
    eop = (state_q == EOP);
  end

  // Datapath decode: a lone low dv clock still carries a data dibit.
  always_comb begin
    frame_end = !dv_q && !dv_prev_q;
    sfd       = (state_q == PREAMBLE) && dv_q && (rx_q == DIBIT_SFD);
    take      = (state_q == DATA) && !frame_end;
    byte_done = take && (idx_q == 2'd3);
    byte_full = {rx_q, asm_q};
  end

  // Byte assembly, count and output strobe next-state.
  always_comb begin
    idx_d   = idx_q;
    asm_d   = asm_q;
    cnt_d   = cnt_q;
    data_d  = data_q;
    valid_d = 1'b0;
    if (sfd) begin
      idx_d = 2'd0;
      cnt_d = '0;
    end else if (take) begin
      idx_d = idx_q + 2'd1;
      asm_d = {rx_q, asm_q[5:2]};
      if (byte_done && (cnt_q < CntW'(MAX_BYTES))) begin
        valid_d = 1'b1;
        data_d  = byte_full;
        cnt_d   = cnt_q + CntW'(1);
      end
    end
  end

  // Datapath registers.
  always_ff @(posedge clk) begin
    if (reset) begin
      idx_q   <= 2'd0;
      asm_q   <= 6'd0;
      cnt_q   <= '0;
      data_q  <= 8'd0;
      valid_q <= 1'b0;
    end else begin
      idx_q   <= idx_d;
      asm_q   <= asm_d;
      cnt_q   <= cnt_d;
      data_q  <= data_d;
      valid_q <= valid_d;
    end
  end

  assign data  = data_q;
  assign valid = valid_q;

`ifdef ETH_RX_CRC_CHECK_EN
  logic [31:0] crc_q, crc_d, crc_next;
  logic        crc_ok_q, crc_ok_d;

  eth_crc32_byte u_crc (
    .crc_i  (crc_q),
    .data_i (byte_full),
    .crc_o  (crc_next)
  );

  // CRC covers every assembled byte, including those past the forwarding limit.
  always_comb begin
    crc_d    = crc_q;
    crc_ok_d = crc_ok_q;
    if (sfd) begin
      crc_d    = ETH_CRC_INIT;
      crc_ok_d = 1'b0;
    end else if (byte_done) begin
      crc_d = crc_next;
    end else if ((state_q == DATA) && frame_end) begin
      crc_ok_d = (crc_q == ETH_CRC_RESIDUE);
    end
  end

  // CRC registers; crc_ok holds from the eop clock until the next SFD.
  always_ff @(posedge clk) begin
    if (reset) begin
      crc_q    <= ETH_CRC_INIT;
      crc_ok_q <= 1'b0;
    end else begin
      crc_q    <= crc_d;
      crc_ok_q <= crc_ok_d;
    end
  end

  assign crc_ok = crc_ok_q;
`endif

endmodule

// File: tb/tb_eth_rmii_rx.sv
// Directed bench for eth_rmii_rx: table of short frames plus hand-built corner sequences.
module tb_eth_rmii_rx;

  logic       clk = 1'b0;
  logic       reset;
  logic [1:0] rmii_rx;
  logic       crs_dv;
  logic [7:0] data;
  logic       valid;
  logic       eop;
`ifdef ETH_RX_CRC_CHECK_EN
  logic       crc_ok;
`endif

  always #5 clk = ~clk;

  eth_rmii_rx #(
    .MAX_BYTES(1536)
  ) dut (
    .clk     (clk),
    .reset   (reset),
    .rmii_rx (rmii_rx),
    .crs_dv  (crs_dv),
    .data    (data),
    .valid   (valid),
    .eop     (eop)
`ifdef ETH_RX_CRC_CHECK_EN
    ,
    .crc_ok  (crc_ok)
`endif
  );

  int tests = 0;
  int fails = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h", name, act, exp);
    end
  endtask

  // Monitor: sampled on the falling edge, away from the active edge.
  int         cyc = 0;
  logic [7:0] rxb[$];
  int         vcyc[$];
  int         eop_cnt = 0;
  int         eop_cyc = 0;
  int         overlap = 0;
  logic       crc_seen = 1'b0;

  always @(negedge clk) begin
    cyc++;
    if (valid === 1'b1) begin
      rxb.push_back(data);
      vcyc.push_back(cyc);
    end
    if (eop === 1'b1) begin
      eop_cnt++;
      eop_cyc = cyc;
      if (valid === 1'b1) overlap++;
`ifdef ETH_RX_CRC_CHECK_EN
      crc_seen = crc_ok;
`endif
    end
  end

  task automatic clear_mon();
    rxb.delete();
    vcyc.delete();
    eop_cnt = 0;
    overlap = 0;
  endtask

  task automatic drv(input logic [1:0] d, input logic dv);
    @(posedge clk);
    #2;
    rmii_rx = d;
    crs_dv  = dv;
  endtask

  task automatic send_pre(input int n);
    repeat (n) drv(2'b01, 1'b1);
    drv(2'b11, 1'b1);
  endtask

  logic [7:0] txb[$];

  function automatic logic [31:0] crc_upd(input logic [31:0] c, input logic [7:0] b);
    logic [31:0] r;
    r = c;
    for (int i = 0; i < 8; i++) begin
      if (r[0] ^ b[i]) r = (r >> 1) ^ 32'hEDB8_8320;
      else r = r >> 1;
    end
    return r;
  endfunction

  task automatic append_fcs();
    logic [31:0] c;
    logic [31:0] fcs;
    c = 32'hFFFF_FFFF;
    foreach (txb[i]) c = crc_upd(c, txb[i]);
    fcs = ~c;
    for (int i = 0; i < 4; i++) txb.push_back(fcs[8*i+:8]);
  endtask

  // Sends txb as a frame; toggle makes dv go 1-0-1-0 over the last byte.
  task automatic send_frame(input bit toggle, input int extra);
    logic [7:0] b;
    logic       dv;
    int         last;
    last = txb.size() - 1;
    send_pre(31);
    for (int i = 0; i < txb.size(); i++) begin
      b = txb[i];
      for (int k = 0; k < 4; k++) begin
        dv = !(toggle && (i == last) && (k == 1 || k == 3));
        drv(b[2*k+:2], dv);
      end
    end
    repeat (extra) drv(2'b10, 1'b1);
    drv(2'b00, 1'b0);
    drv(2'b00, 1'b0);
    for (int w = 0; w < 30 && eop_cnt == 0; w++) @(negedge clk);
    repeat (6) drv(2'b00, 1'b0);
  endtask

  task automatic check_frame(input string name, input int exp_n);
    int bad;
    int n;
    int mingap;
    int maxgap;
    n = (rxb.size() < exp_n) ? rxb.size() : exp_n;
    check({name, " count"}, rxb.size(), exp_n);
    bad = 0;
    for (int i = 0; i < n; i++) if (rxb[i] !== txb[i]) bad++;
    check({name, " bytes"}, bad, 0);
    check({name, " eop"}, eop_cnt, 1);
    check({name, " overlap"}, overlap, 0);
    if (rxb.size() >= 2) begin
      mingap = 1 << 30;
      maxgap = 0;
      for (int i = 1; i < vcyc.size(); i++) begin
        if (vcyc[i] - vcyc[i-1] < mingap) mingap = vcyc[i] - vcyc[i-1];
        if (vcyc[i] - vcyc[i-1] > maxgap) maxgap = vcyc[i] - vcyc[i-1];
      end
      check({name, " min gap"}, mingap, 4);
      check({name, " max gap"}, maxgap, 4);
    end
    if (rxb.size() > 0) check({name, " eop after last"}, eop_cyc > vcyc[vcyc.size()-1], 1);
  endtask

  typedef struct {
    int          n;
    logic [31:0] bytes;
    int          extra;
    bit          toggle;
    int          exp_n;
  } vec_t;

  vec_t tbl[5];

  task automatic load_vec(input vec_t v);
    logic [31:0] w;
    w = v.bytes;
    txb.delete();
    for (int i = 0; i < v.n; i++) txb.push_back(w[8*i+:8]);
  endtask

  initial begin
    #5_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    int nb;
    tbl[0] = '{n: 4, bytes: 32'h8001_AA55, extra: 0, toggle: 1'b0, exp_n: 4};
    tbl[1] = '{n: 2, bytes: 32'h0000_C33C, extra: 2, toggle: 1'b0, exp_n: 2};
    tbl[2] = '{n: 1, bytes: 32'h0000_00FF, extra: 0, toggle: 1'b0, exp_n: 1};
    tbl[3] = '{n: 3, bytes: 32'h007E_810F, extra: 0, toggle: 1'b1, exp_n: 3};
    tbl[4] = '{n: 0, bytes: 32'h0000_0000, extra: 2, toggle: 1'b0, exp_n: 0};

    reset   = 1'b1;
    rmii_rx = 2'b00;
    crs_dv  = 1'b0;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("reset valid", valid, 0);
    check("reset eop", eop, 0);
    check("reset data", data, 0);
`ifdef ETH_RX_CRC_CHECK_EN
    check("reset crc_ok", crc_ok, 0);
`endif
    @(posedge clk);
    #2;
    reset = 1'b0;
    repeat (3) drv(2'b00, 1'b0);

    for (int t = 0; t < 5; t++) begin
      clear_mon();
      load_vec(tbl[t]);
      send_frame(tbl[t].toggle, tbl[t].extra);
      check_frame($sformatf("vec%0d", t), tbl[t].exp_n);
    end

    // 64-byte frame with good FCS, dv toggling at the tail.
    txb.delete();
    for (int i = 0; i < 60; i++) txb.push_back(8'((i * 7 + 3) & 8'hFF));
    append_fcs();
    clear_mon();
    send_frame(1'b1, 0);
    check_frame("fcs good", 64);
`ifdef ETH_RX_CRC_CHECK_EN
    check("fcs good crc_ok", crc_seen, 1);
`endif

    // Same frame with one payload bit flipped.
    txb[5] = txb[5] ^ 8'h10;
    clear_mon();
    send_frame(1'b1, 0);
    check_frame("fcs bad", 64);
`ifdef ETH_RX_CRC_CHECK_EN
    check("fcs bad crc_ok", crc_seen, 0);
`endif

    // Oversize frame: forwarding stops at the limit, eop still follows.
    txb.delete();
    for (int i = 0; i < 1600; i++) txb.push_back(8'(i & 255));
    clear_mon();
    send_frame(1'b0, 0);
    check_frame("oversize", 1536);

    // Reset mid-frame: no further output until a fresh SFD.
    clear_mon();
    send_pre(31);
    for (int i = 0; i < 10; i++) begin
      for (int k = 0; k < 4; k++) drv(2'b10, 1'b1);
    end
    @(posedge clk);
    #2;
    reset = 1'b1;
    @(negedge clk);
    @(negedge clk);
    check("midreset valid", valid, 0);
    check("midreset data", data, 0);
    @(posedge clk);
    #2;
    reset = 1'b0;
    nb = rxb.size();
    check("midreset eop before", eop_cnt, 0);
    repeat (40) drv(2'b00, 1'b1);
    repeat (8) drv(2'b00, 1'b0);
    check("midreset no bytes", rxb.size(), nb);
    check("midreset no eop", eop_cnt, 0);

    // Dibit 10 inside the preamble drops the frame silently.
    clear_mon();
    repeat (5) drv(2'b01, 1'b1);
    drv(2'b10, 1'b1);
    repeat (20) drv(2'b01, 1'b1);
    drv(2'b11, 1'b1);
    for (int k = 0; k < 16; k++) drv(2'b01, 1'b1);
    repeat (8) drv(2'b00, 1'b0);
    check("drop bytes", rxb.size(), 0);
    check("drop eop", eop_cnt, 0);

    // Recovery after drop.
    clear_mon();
    load_vec(tbl[0]);
    send_frame(1'b0, 0);
    check_frame("recover", 4);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
